// File: rtl/slice_arbiter.sv
// slice_arbiter
// -------------
// Round-robin arbiter that shares one resource between PORTS requesters.
// Every grant is a time slice of at most 2^CNT_WIDTH cycles. A slice ends
// early when the owner drops its request or when io_enable goes low. After
// each release there is always one idle cycle before the next grant. The
// search for the next owner then starts at the requester after the one just
// released.
//
// Ports:
//   clk            in   clock, all state on the rising edge
//   reset          in   asynchronous, active-high reset
//   io_enable      in   arbitration enable; low releases and blocks grants
//   io_req         in   [PORTS]      request vector, bit i = requester i
//   io_grant       out  [PORTS]      registered one-hot grant, zero when idle
//   io_grantValid  out  1            OR of io_grant
//   io_grantId     out  [ID_W]       current owner; holds last owner when idle
//   io_sliceValue  out  [CNT_WIDTH]  cycles elapsed in the current slice
//   io_sliceFull   out  1            slice counter at all-ones while granted
module slice_arbiter #(
    parameter int PORTS     = 4,
    parameter int CNT_WIDTH = 4,
    localparam int ID_W     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_enable,
    input  logic [PORTS-1:0]     io_req,
    output logic [PORTS-1:0]     io_grant,
    output logic                 io_grantValid,
    output logic [ID_W-1:0]      io_grantId,
    output logic [CNT_WIDTH-1:0] io_sliceValue,
    output logic                 io_sliceFull
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PORTS-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // rot_idx[k] is the requester examined k-th in the scan, i.e.
    // (ptr + k) mod PORTS. rot_req[k] is that requester's request.
    logic [ID_W-1:0]  rot_idx [PORTS];
    logic [PORTS-1:0] rot_req;
    logic [ID_W-1:0]  win_id;
    logic [PORTS-1:0] win_onehot;
    logic             slice_full;
    logic             release_now;

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_rot
            logic [ID_W:0] sum_w;
            // The sum is at most 2*PORTS-2. A single conditional subtract
            // therefore gives the modulo, also when PORTS is not a power of two.
            assign sum_w       = {1'b0, ptr_q} + (ID_W+1)'(gi);
            assign rot_idx[gi] = ID_W'((sum_w >= (ID_W+1)'(PORTS)) ?
                                       (sum_w - (ID_W+1)'(PORTS)) : sum_w);
            assign rot_req[gi] = io_req[rot_idx[gi]];
        end
    endgenerate

    // Winner: the first set bit of the rotated vector. The loop runs from the
    // highest index down, so the lowest offset is assigned last and wins.
    always_comb begin
        win_id = rot_idx[0];
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_id = rot_idx[k];
            end
        end
    end

    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_id == ID_W'(gi));
        end
    endgenerate

    assign slice_full  = (state_q == GRANT) && (&cnt_q);
    assign release_now = !io_req[id_q] || slice_full || !io_enable;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (io_enable && (|io_req)) begin
                    state_d = GRANT;
                    grant_d = win_onehot;
                    id_d    = win_id;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = (id_q == ID_W'(PORTS - 1)) ? '0 : id_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign io_grant      = grant_q;
    assign io_grantValid = |grant_q;
    assign io_grantId    = id_q;
    assign io_sliceValue = cnt_q;
    assign io_sliceFull  = slice_full;

endmodule

// File: tb/tb_slice_arbiter.sv
// Testbench for slice_arbiter (PORTS=4, CNT_WIDTH=4). A table of per-cycle
// vectors covers the slice, round-robin and early-release sequences. Short
// hand-written sequences cover io_enable gating and asynchronous reset
// in the middle of a slice.
module tb_slice_arbiter;

    localparam int PORTS     = 4;
    localparam int CNT_WIDTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       io_enable;
    logic [3:0] io_req;
    logic [3:0] io_grant;
    logic       io_grantValid;
    logic [1:0] io_grantId;
    logic [3:0] io_sliceValue;
    logic       io_sliceFull;

    slice_arbiter #(
        .PORTS     (PORTS),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_enable     (io_enable),
        .io_req        (io_req),
        .io_grant      (io_grant),
        .io_grantValid (io_grantValid),
        .io_grantId    (io_grantId),
        .io_sliceValue (io_sliceValue),
        .io_sliceFull  (io_sliceFull)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] id;
        logic [3:0] sv;
        logic       full;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic rst, input logic en, input logic [3:0] req,
                        input logic [3:0] g, input logic [1:0] id,
                        input logic [3:0] sv, input logic full);
        vec_t v;
        v.rst = rst; v.en = en; v.req = req; v.g = g;
        v.id = id; v.sv = sv; v.full = full;
        vecs.push_back(v);
    endtask

    task automatic add_rst();
        push(1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 4'd0, 1'b0);
    endtask

    // n consecutive grant cycles to 'id', with the slice value counting from 0.
    task automatic add_slice(input logic en, input logic [3:0] req,
                             input logic [1:0] id, input int n);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        for (int s = 0; s < n; s++) begin
            push(1'b0, en, req, oh, id, 4'(s), (s == 15));
        end
    endtask

    task automatic add_idle(input logic en, input logic [3:0] req, input logic [1:0] id);
        push(1'b0, en, req, 4'b0000, id, 4'd0, 1'b0);
    endtask

    // Drive one cycle of inputs and sample 1 time unit after the rising edge.
    task automatic cyc(input logic en, input logic [3:0] req);
        io_enable = en;
        io_req    = req;
        @(posedge clk);
        #1;
    endtask

    task automatic check_inv(input string tag);
        chk({tag, " onehot0"}, 32'($onehot0(io_grant)), 32'd1);
        chk({tag, " valid_or"}, 32'(io_grantValid), 32'(|io_grant));
        if (!io_grantValid) chk({tag, " full_idle"}, 32'(io_sliceFull), 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic [3:0] sv, input logic full);
        $display("%s: grant=%b id=%0d slice=%0d full=%b", tag, io_grant, io_grantId,
                 io_sliceValue, io_sliceFull);
        chk({tag, " grant"}, 32'(io_grant), 32'(g));
        chk({tag, " valid"}, 32'(io_grantValid), 32'(g != 4'b0000));
        chk({tag, " id"}, 32'(io_grantId), 32'(id));
        chk({tag, " slice"}, 32'(io_sliceValue), 32'(sv));
        chk({tag, " full"}, 32'(io_sliceFull), 32'(full));
        check_inv(tag);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        io_enable = 1'b1;
        io_req    = 4'b0000;
        @(posedge clk);
        #1;
        expect_out("reset", 4'b0000, 2'd0, 4'd0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        io_enable = 1'b0;
        io_req    = 4'b0000;

        // Single requester: two full slices separated by one idle cycle.
        add_rst();
        add_slice(1'b1, 4'b0001, 2'd0, 16);
        add_idle (1'b1, 4'b0001, 2'd0);
        add_slice(1'b1, 4'b0001, 2'd0, 16);
        add_idle (1'b1, 4'b0000, 2'd0);
        add_idle (1'b1, 4'b0000, 2'd0);

        // All requesting: order 0,1,2,3,0.
        add_rst();
        for (int p = 0; p < 4; p++) begin
            add_slice(1'b1, 4'b1111, 2'(p), 16);
            add_idle (1'b1, 4'b1111, 2'(p));
        end
        add_slice(1'b1, 4'b1111, 2'd0, 16);

        // 0101: alternation 0,2,0,2.
        add_rst();
        add_slice(1'b1, 4'b0101, 2'd0, 16);
        add_idle (1'b1, 4'b0101, 2'd0);
        add_slice(1'b1, 4'b0101, 2'd2, 16);
        add_idle (1'b1, 4'b0101, 2'd2);
        add_slice(1'b1, 4'b0101, 2'd0, 16);
        add_idle (1'b1, 4'b0101, 2'd0);
        add_slice(1'b1, 4'b0101, 2'd2, 3);

        // Requester 1 drops at slice value 5. Requesters 0 and 3 are asking,
        // so the next grant goes to 3, the first at or after index 2.
        add_rst();
        add_slice(1'b1, 4'b0010, 2'd1, 6);
        add_idle (1'b1, 4'b1001, 2'd1);
        add_slice(1'b1, 4'b1001, 2'd3, 2);

        foreach (vecs[i]) begin
            string tag;
            reset = vecs[i].rst;
            cyc(vecs[i].en, vecs[i].req);
            tag = $sformatf("vec%0d rst=%b en=%b req=%b", i, vecs[i].rst, vecs[i].en, vecs[i].req);
            expect_out(tag, vecs[i].g, vecs[i].id, vecs[i].sv, vecs[i].full);
        end
        reset = 1'b0;

        // io_enable low at slice value 3: release, hold off, resume with 1.
        do_reset();
        for (int s = 0; s < 4; s++) begin
            cyc(1'b1, 4'b1111);
            expect_out($sformatf("en_grant s%0d", s), 4'b0001, 2'd0, 4'(s), 1'b0);
        end
        for (int s = 0; s < 3; s++) begin
            cyc(1'b0, 4'b1111);
            expect_out($sformatf("en_low c%0d", s), 4'b0000, 2'd0, 4'd0, 1'b0);
        end
        cyc(1'b1, 4'b1111);
        expect_out("en_resume", 4'b0010, 2'd1, 4'd0, 1'b0);

        // Asynchronous reset in the middle of a slice. Granting and releasing
        // requester 1 first moves the pointer to 2, which lets the check
        // after reset show that the pointer went back to 0.
        do_reset();
        cyc(1'b1, 4'b0010);
        expect_out("ar_g1", 4'b0010, 2'd1, 4'd0, 1'b0);
        cyc(1'b1, 4'b1000);
        expect_out("ar_rel1", 4'b0000, 2'd1, 4'd0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            cyc(1'b1, 4'b1000);
            expect_out($sformatf("ar_g3 s%0d", s), 4'b1000, 2'd3, 4'(s), 1'b0);
        end
        #3;
        reset = 1'b1;
        #1;
        expect_out("ar_async", 4'b0000, 2'd0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        expect_out("ar_hold", 4'b0000, 2'd0, 4'd0, 1'b0);
        reset = 1'b0;
        cyc(1'b1, 4'b1001);
        expect_out("ar_ptr0", 4'b0001, 2'd0, 4'd0, 1'b0);
        cyc(1'b1, 4'b0000);
        expect_out("ar_rel0", 4'b0000, 2'd0, 4'd0, 1'b0);
        cyc(1'b1, 4'b1000);
        expect_out("ar_g3b", 4'b1000, 2'd3, 4'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slice_arbiter.md
Name: slice_arbiter

Overview:
Round-robin arbiter that shares one resource between PORTS requesters, using a time-slice counter with clear and full-detect. Each grant lasts at most 2^CNT_WIDTH cycles and is released early when the owner drops its request. Sits in front of any shared datapath or bus that the requesters must use one at a time; it drives the datapath's select via io_grantId.

Parameters:
PORTS, 4, number of requesters (>=2)
CNT_WIDTH, 4, slice counter width; maximum slice length = 2^CNT_WIDTH cycles

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
io_enable  in  1  arbitration enable; low forces release and blocks new grants
io_req  in  PORTS  request vector, bit i = requester i
io_grant  out  PORTS  one-hot grant, registered, all-zero when idle
io_grantValid  out  1  OR of io_grant
io_grantId  out  log2Up(PORTS)  index of current owner; holds last owner when idle
io_sliceValue  out  CNT_WIDTH  cycles elapsed in current slice (0 on first grant cycle)
io_sliceFull  out  1  io_sliceValue == all-ones while granted

Behaviour:
- Clock and reset: all state is on clk rising edge, with reset asynchronous, active-high.
- Reset values: state=IDLE, io_grant=0, io_grantValid=0, io_grantId=0, round-robin pointer ptr=0, slice counter=0, io_sliceFull=0.
- States: IDLE and GRANT.
- IDLE, cycle t, with io_enable=1 and io_req!=0:
  - winner = first i with io_req[i]=1, scanning ptr, ptr+1, ... mod PORTS.
  - At t+1: state=GRANT, io_grant=onehot(winner), io_grantId=winner, counter=0.
  - Otherwise remain in IDLE with outputs unchanged.
- GRANT, each cycle, release is required if any of:
  - io_req[owner]=0,
  - counter == all-ones (io_sliceFull=1),
  - io_enable=0.
- On release at cycle t:
  - At t+1: state=IDLE, io_grant=0, counter=0.
  - ptr = (owner+1) mod PORTS, wrapping from PORTS-1 to 0.
- Otherwise the counter increments by 1. It never wraps inside a slice because the full condition forces release.
- Gap between grants: exactly one IDLE cycle between consecutive grants, including when the same requester re-wins.
- Latency:
  - Request to grant: 1 cycle from IDLE.
  - Request drop to grant drop: 1 cycle, so the owner holds the resource one cycle after deasserting io_req.
- Maximum slice: io_grant high for exactly 2^CNT_WIDTH cycles, io_sliceValue 0..2^CNT_WIDTH-1.
- Simultaneous events: when full and request drop coincide, a single release occurs with the same ptr update.
- io_req of non-owners is ignored during GRANT.
- io_grant is one-hot or zero in every cycle.
- io_sliceFull is 0 whenever io_grantValid=0.
- Reset mid-grant: outputs return to reset values immediately (asynchronous) and ptr returns to 0.

Test Plan:
- Reset, io_enable=1, io_req=0001 held -> io_grant=0001 from cycle 1 for 16 cycles (sliceValue 0..15, sliceFull only at 15), 1 idle cycle, then re-granted for 16 cycles.
- io_req=1111 held from reset -> grant order 0,1,2,3,0, each 16 cycles, separated by single idle cycles; io_grantId follows.
- io_req=0101 held -> alternation 0,2,0,2; requesters 1 and 3 never granted.
- Requester 1 granted, drops io_req at slice cycle 5 -> io_grant=0 at slice cycle 6; next grant goes to the first requester at or after index 2.
- io_enable driven low during a grant at slice cycle 3 -> grant drops next cycle; no new grant while io_enable=0 despite io_req=1111; resumes 1 cycle after io_enable returns high.
- Reset asserted asynchronously mid-slice with io_req=1000 -> io_grant=0 and counter=0 at once; after release requester 3 is granted, and ptr=0 ordering is verified on the next request from requester 0.
